// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: accepts a WIDTH-bit word on a valid/ready handshake
// and emits it one bit per cycle, back-to-back frames with no gap.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sequence_out,
    output logic             bit_valid,
    output logic             frame_done,
    output logic             busy
);

    // state | meaning
    // IDLE  | no frame active, line held at IDLE_BIT
    // SHIFT | frame in progress, bit_cnt_q is the bit currently on the line
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             seq_q, seq_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             load_xfer;

    assign load_ready = (state_q == IDLE) || (bit_cnt_q == CNT_LAST);
    assign load_xfer  = load_valid && load_ready;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        seq_d     = IDLE_BIT;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        busy_d    = 1'b0;

        if (load_xfer) begin
            state_d   = SHIFT;
            bit_cnt_d = '0;
            shreg_d   = data_in;
            seq_d     = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
            valid_d   = 1'b1;
            busy_d    = 1'b1;
        end else if (state_q == SHIFT) begin
            if (bit_cnt_q == CNT_LAST) begin
                // bit_cnt_q is left alone here; it only wraps on a back-to-back load
                state_d = IDLE;
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (MSB_FIRST) begin
                    shreg_d = shreg_q << 1;
                    seq_d   = shreg_q[WIDTH-2];
                end else begin
                    shreg_d = shreg_q >> 1;
                    seq_d   = shreg_q[1];
                end
                valid_d = 1'b1;
                busy_d  = 1'b1;
                done_d  = (bit_cnt_d == CNT_LAST);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            seq_q     <= IDLE_BIT;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            seq_q     <= seq_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign sequence_out = seq_q;
    assign bit_valid    = valid_q;
    assign frame_done   = done_q;
    assign busy         = busy_q;

endmodule
